id_ex_operand_stage: RTL

- ID/EX pipeline register for the 5-stage MIPS core, plus the EX-side operand forwarding muxes that drive the ALU's x, y and 4-bit signals inputs.
- Captures decoded fields, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- On a load-use hazard it inserts a bubble and requests an IF/ID stall.

---
 rtl/mips_pkg.sv | 35 +++
 rtl/id_ex_operand_stage_fwd_select.sv | 34 +++
 rtl/id_ex_operand_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALU operation codes and the
// control bundle carried through the ID/EX pipeline register.
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  // Control bits that travel with an instruction from ID into EX.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_imm;
    logic       shift_imm;
    logic [3:0] alu_signals;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '0;

  // All shift operations share the top bit of the ALU code.
  function automatic logic is_shift_op(input logic [3:0] sig);
    return sig[3];
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Priority forwarding mux for one EX source register. A newer result in
// EX/MEM beats an older one in MEM/WB; register 0 is hard-wired to zero in
// the register file and must never pick up a forwarded value.
module fwd_select #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic [RA_W-1:0]  src_i,
  input  logic [WIDTH-1:0] reg_data_i,
  input  logic             exmem_reg_write_i,
  input  logic [RA_W-1:0]  exmem_rd_i,
  input  logic [WIDTH-1:0] exmem_result_i,
  input  logic             memwb_reg_write_i,
  input  logic [RA_W-1:0]  memwb_rd_i,
  input  logic [WIDTH-1:0] memwb_result_i,
  output logic [WIDTH-1:0] fwd_data_o
);

  logic exmem_hit;
  logic memwb_hit;

  // Pick the youngest in-flight producer of the source register, else the file value.
  always_comb begin
    exmem_hit  = exmem_reg_write_i & (exmem_rd_i != '0) & (exmem_rd_i == src_i);
    memwb_hit  = memwb_reg_write_i & (memwb_rd_i != '0) & (memwb_rd_i == src_i);
    fwd_data_o = reg_data_i;
    if (exmem_hit) begin
      fwd_data_o = exmem_result_i;
    end else if (memwb_hit) begin
      fwd_data_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection. A load in EX whose destination is read by the ID
// instruction turns the next capture into a bubble and freezes IF/ID.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add a 32-bit bubble_count
// output counting bubbles written because of a hazard or a flush.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_shamt,
  input  logic [3:0]       id_alu_signals,
  input  logic             id_alu_src_imm,
  input  logic             id_shift_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [3:0]       alu_signals,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RA_W-1:0]  ex_rd,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             load_use_stall
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]      bubble_count
`endif
);

  idex_ctrl_t       ctrl_q,    ctrl_d;
  logic [RA_W-1:0]  rd_q,      rd_d;
  logic [RA_W-1:0]  rs_q,      rs_d;
  logic [RA_W-1:0]  rt_q,      rt_d;
  logic [WIDTH-1:0] rs_data_q, rs_data_d;
  logic [WIDTH-1:0] rt_data_q, rt_data_d;
  logic [WIDTH-1:0] imm_q,     imm_d;
  logic [4:0]       shamt_q,   shamt_d;

  logic             hazard;
  logic             bubble_w;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  // A load in EX cannot forward in time to an ID instruction that reads its target.
  always_comb begin
    hazard = id_valid & ctrl_q.valid & ctrl_q.mem_read & (rd_q != '0) &
             ((rd_q == id_rs) | (rd_q == id_rt));
    load_use_stall = hazard & ~flush;
  end

  // Next-state selection: flush beats stall, stall beats hazard, else capture ID.
  always_comb begin
    ctrl_d    = ctrl_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    shamt_d   = shamt_q;
    bubble_w  = 1'b0;
    if (flush) begin
      bubble_w = 1'b1;
    end else if (stall) begin
      bubble_w = 1'b0;
    end else if (hazard) begin
      bubble_w = 1'b1;
    end else begin
      ctrl_d.valid       = id_valid;
      ctrl_d.reg_write   = id_reg_write;
      ctrl_d.mem_read    = id_mem_read;
      ctrl_d.mem_write   = id_mem_write;
      ctrl_d.alu_src_imm = id_alu_src_imm;
      ctrl_d.shift_imm   = id_shift_imm;
      ctrl_d.alu_signals = id_alu_signals;
      rd_d      = id_rd;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      shamt_d   = id_shamt;
    end
    if (bubble_w) begin
      ctrl_d    = IDEX_CTRL_BUBBLE;
      rd_d      = '0;
      rs_d      = '0;
      rt_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      shamt_d   = '0;
    end
  end

  // The pipeline register itself; reset leaves an empty, side-effect-free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= IDEX_CTRL_BUBBLE;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      shamt_q   <= shamt_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Count every bubble written by a flush or hazard; a held register is not a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (bubble_w) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_count = bubble_cnt_q;
`endif

  fwd_select #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rs (
    .src_i             (rs_q),
    .reg_data_i        (rs_data_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_result_i    (memwb_result),
    .fwd_data_o        (fwd_rs)
  );

  fwd_select #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rt (
    .src_i             (rt_q),
    .reg_data_i        (rt_data_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_result_i    (exmem_result),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_result_i    (memwb_result),
    .fwd_data_o        (fwd_rt)
  );

  // Shifts operate on rt by shamt or rs[4:0]; everything else is rs op (imm or rt).
  always_comb begin
    if (is_shift_op(ctrl_q.alu_signals)) begin
      alu_x = fwd_rt;
      if (ctrl_q.shift_imm) begin
        alu_y = {{(WIDTH-5){1'b0}}, shamt_q};
      end else begin
        alu_y = {{(WIDTH-5){1'b0}}, fwd_rs[4:0]};
      end
    end else begin
      alu_x = fwd_rs;
      alu_y = ctrl_q.alu_src_imm ? imm_q : fwd_rt;
    end
    alu_signals   = ctrl_q.alu_signals;
    ex_store_data = fwd_rt;
    ex_rd         = rd_q;
    ex_valid      = ctrl_q.valid;
    ex_reg_write  = ctrl_q.reg_write;
    ex_mem_read   = ctrl_q.mem_read;
    ex_mem_write  = ctrl_q.mem_write;
  end

endmodule
